// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control path: FSM states, opcodes,
// funct codes, ALU commands and the datapath mux select encodings.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_XORI  = 6'd14;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_JR      = 6'd8;
  localparam logic [5:0] FN_SYSCALL = 6'd12;
  localparam logic [5:0] FN_ADD     = 6'd32;
  localparam logic [5:0] FN_SUB     = 6'd34;
  localparam logic [5:0] FN_XOR     = 6'd38;
  localparam logic [5:0] FN_SLT     = 6'd42;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_REG    = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_BRANCH = 2'd3;

  localparam logic [1:0] DST_RD = 2'd0;
  localparam logic [1:0] DST_RT = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MDR = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;

  localparam logic [1:0] SRCB_RT   = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;

  localparam logic SRCA_PC = 1'b0;
  localparam logic SRCA_RS = 1'b1;

  // ALU operation used from EXEC onward; address arithmetic for lw/sw is an ADD.
  function automatic logic [2:0] alu_op_of(input logic [5:0] op, input logic [5:0] fn);
    logic [2:0] cmd;
    cmd = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_SUB:  cmd = ALU_SUB;
          FN_SLT:  cmd = ALU_SLT;
          FN_XOR:  cmd = ALU_XOR;
          default: cmd = ALU_ADD;
        endcase
      end
      OP_BEQ, OP_BNE: cmd = ALU_SUB;
      OP_SLTI:        cmd = ALU_SLT;
      OP_XORI:        cmd = ALU_XOR;
      default:        cmd = ALU_ADD;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/instr_fields.sv
// Combinational split of the latched instruction into register fields, the
// extended immediate (zero-extended for xori, sign-extended otherwise) and jump target.
module instr_fields
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int JIMM_W = 28
) (
  input  logic [31:0]       ir,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [DATA_W-1:0] immExt,
  output logic [JIMM_W-1:0] jImm
);

  logic zero_ext;

  assign zero_ext = (ir[31:26] == OP_XORI);
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign immExt   = zero_ext ? {{(DATA_W-16){1'b0}}, ir[15:0]}
                             : {{(DATA_W-16){ir[15]}}, ir[15:0]};
  assign jImm     = {ir[25:0], 2'b00};

endmodule

// File: rtl/multicycle_decoder.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and drives datapath enables.
// Optional macro ILLEGAL_TRAP_EN sends unsupported encodings to a sticky TRAP state.
module multicycle_decoder
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int JIMM_W = 28
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       memRdata,
  input  logic              memReady,
  input  logic              aluZero,
  output logic              memReq,
  output logic              memWrEn,
  output logic              iorD,
  output logic              irWrEn,
  output logic              pcWrEn,
  output logic [1:0]        pcSrc,
  output logic              regWrEn,
  output logic [1:0]        regDst,
  output logic [1:0]        writebackSrc,
  output logic              aluSrcA,
  output logic [1:0]        aluSrcB,
  output logic [2:0]        aluCommand,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [DATA_W-1:0] immExt,
  output logic [JIMM_W-1:0] jImm,
  output logic              halted,
  output logic              illegal,
  output logic [2:0]        state
);

`ifdef ILLEGAL_TRAP_EN
  localparam state_t BAD_NEXT = S_TRAP;
`else
  localparam state_t BAD_NEXT = S_FETCH;
`endif

  state_t      cur;
  state_t      nxt;
  logic [31:0] ir;
  logic [5:0]  op;
  logic [5:0]  fn;
  logic        is_rtype;
  logic        is_ralu;
  logic        is_jr;
  logic        is_sys;
  logic        is_j;
  logic        is_jal;
  logic        is_beq;
  logic        is_bne;
  logic        is_br;
  logic        is_ialu;
  logic        is_lw;
  logic        is_sw;
  logic        is_exec;
  logic        ir_load;
  logic        mem_req;
  logic        mem_wr;
  logic        pc_wr;
  logic        reg_wr;

  assign op       = ir[31:26];
  assign fn       = ir[5:0];
  assign is_rtype = (op == OP_RTYPE);
  assign is_ralu  = is_rtype && ((fn == FN_ADD) || (fn == FN_SUB) ||
                                 (fn == FN_SLT) || (fn == FN_XOR));
  assign is_jr    = is_rtype && (fn == FN_JR);
  assign is_sys   = is_rtype && (fn == FN_SYSCALL);
  assign is_j     = (op == OP_J);
  assign is_jal   = (op == OP_JAL);
  assign is_beq   = (op == OP_BEQ);
  assign is_bne   = (op == OP_BNE);
  assign is_br    = is_beq || is_bne;
  assign is_ialu  = (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_SLTI) || (op == OP_XORI);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign is_exec  = is_ralu || is_ialu || is_br || is_lw || is_sw;
  assign ir_load  = (cur == S_FETCH) && memReady;

  instr_fields #(
    .DATA_W(DATA_W),
    .JIMM_W(JIMM_W)
  ) u_fields (
    .ir    (ir),
    .rs    (rs),
    .rt    (rt),
    .rd    (rd),
    .immExt(immExt),
    .jImm  (jImm)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= S_FETCH;
      ir  <= '0;
    end else begin
      cur <= nxt;
      if (ir_load) ir <= memRdata;
    end
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_FETCH:  if (memReady) nxt = S_DECODE;
      S_DECODE: begin
        if (is_j || is_jal || is_jr) nxt = S_FETCH;
        else if (is_sys)             nxt = S_HALT;
        else if (is_exec)            nxt = S_EXEC;
        else                         nxt = BAD_NEXT;
      end
      S_EXEC: begin
        if (is_br)              nxt = S_FETCH;
        else if (is_lw || is_sw) nxt = S_MEM;
        else                    nxt = S_WB;
      end
      S_MEM:    if (memReady) nxt = is_sw ? S_FETCH : S_WB;
      S_WB:     nxt = S_FETCH;
      S_HALT:   nxt = S_HALT;
      S_TRAP:   nxt = S_TRAP;
      default:  nxt = S_FETCH;
    endcase
  end

  // ALU selects computed in EXEC stay applied through MEM/WB so the address is stable.
  always_comb begin
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    iorD         = 1'b0;
    pc_wr        = 1'b0;
    pcSrc        = PC_PLUS4;
    reg_wr       = 1'b0;
    regDst       = DST_RD;
    writebackSrc = WB_ALU;
    aluSrcA      = SRCA_PC;
    aluSrcB      = SRCB_RT;
    aluCommand   = ALU_ADD;
    case (cur)
      S_FETCH: begin
        mem_req = 1'b1;
        aluSrcB = SRCB_FOUR;
        pc_wr   = memReady;
      end
      S_DECODE: begin
        if (is_j || is_jal) begin
          pc_wr = 1'b1;
          pcSrc = PC_JUMP;
        end
        if (is_jal) begin
          reg_wr       = 1'b1;
          regDst       = DST_RA;
          writebackSrc = WB_PC;
        end
        if (is_jr) begin
          pc_wr = 1'b1;
          pcSrc = PC_REG;
        end
      end
      S_EXEC, S_MEM, S_WB: begin
        aluSrcA    = SRCA_RS;
        aluSrcB    = (is_ralu || is_br) ? SRCB_RT : SRCB_IMM;
        aluCommand = alu_op_of(op, fn);
        if (cur == S_EXEC && is_br) begin
          pcSrc = PC_BRANCH;
          pc_wr = is_beq ? aluZero : !aluZero;
        end
        if (cur == S_MEM) begin
          mem_req = 1'b1;
          iorD    = 1'b1;
          mem_wr  = is_sw;
        end
        if (cur == S_WB) begin
          reg_wr       = 1'b1;
          regDst       = is_ralu ? DST_RD : DST_RT;
          writebackSrc = is_lw ? WB_MDR : WB_ALU;
        end
      end
      default: ;
    endcase
  end

  assign memReq  = mem_req && !reset;
  assign memWrEn = mem_wr && !reset;
  assign irWrEn  = ir_load && !reset;
  assign pcWrEn  = pc_wr && !reset;
  assign regWrEn = reg_wr && !reset;
  assign halted  = (cur == S_HALT) && !reset;
  assign state   = cur;

`ifdef ILLEGAL_TRAP_EN
  assign illegal = (cur == S_TRAP) && !reset;
`else
  assign illegal = 1'b0;
`endif

endmodule
